// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: memory request side, instruction delivery side,
// controller decision inputs and status flags.
//
// Handshakes:
//   memory  - inst_req is held high while the unit waits for a word; the word on
//             inst_rdata is accepted in any cycle where inst_req && MIO_ready.
//             MIO_ready while inst_req is low is ignored.
//   consumer - inst_valid is held high with inst/OPcode/Fun/pc_out stable until
//             the cycle where inst_valid && inst_ack; Jump/Branch/Zero are only
//             sampled in that cycle. inst_ack while inst_valid is low is ignored.
interface ifetch_unit_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        MIO_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [5:0]  OPcode;
  logic [5:0]  Fun;
  logic [31:0] pc_out;
  logic        inst_ack;
  logic        Jump;
  logic        Branch;
  logic        Zero;
  logic        fetch_err;
  logic [1:0]  state_dbg;

  modport master (
    output inst_req, inst_addr, inst_valid, inst, OPcode, Fun, pc_out,
           fetch_err, state_dbg,
    input  inst_rdata, MIO_ready, inst_ack, Jump, Branch, Zero
  );

  modport slave (
    input  inst_req, inst_addr, inst_valid, inst, OPcode, Fun, pc_out,
           fetch_err, state_dbg,
    output inst_rdata, MIO_ready, inst_ack, Jump, Branch, Zero
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: holds the PC, requests one word at a time from
// memory, presents it in the IR until the consumer acknowledges it, then
// advances the PC (sequential, branch or jump).
// Optional macro FETCH_TIMEOUT_EN adds a 255-cycle fetch timeout that parks
// the unit in ERR with a sticky fetch_err until reset.
module ifetch_unit (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

  state_t      state;
  state_t      state_next;

  // PC and captured PC are kept as word addresses so byte bits [1:0] are
  // zero by construction; 30-bit wrap equals 32-bit byte-address wrap.
  logic [29:0] pc_w;
  logic [29:0] pc_w4;
  logic [29:0] pc_w_next;
  logic [29:0] pc_out_w;
  logic [31:0] ir;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0]  cnt;
  logic        err_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = REQ;
      REQ: begin
        if (bus.MIO_ready) state_next = VALID;
`ifdef FETCH_TIMEOUT_EN
        else if (cnt == 8'hFF) state_next = ERR;
`endif
      end
      VALID: if (bus.inst_ack) state_next = REQ;
      ERR:   state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // Next PC on an accepted ack: jump beats taken branch beats sequential.
  always_comb begin
    pc_w4     = pc_w + 30'd1;
    pc_w_next = pc_w4;
    if (bus.Jump)
      pc_w_next = {pc_w4[29:26], ir[25:0]};
    else if (bus.Branch && bus.Zero)
      pc_w_next = pc_w4 + {{14{ir[15]}}, ir[15:0]};
  end

  // PC, IR and captured-PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_w     <= '0;
      ir       <= '0;
      pc_out_w <= '0;
    end else begin
      if (state == REQ && bus.MIO_ready) begin
        ir       <= bus.inst_rdata;
        pc_out_w <= pc_w;
      end
      if (state == VALID && bus.inst_ack)
        pc_w <= pc_w_next;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Timeout counter: zero outside REQ, counts stalled REQ cycles; error sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == REQ) begin
        if (!bus.MIO_ready && cnt != 8'hFF) cnt <= cnt + 8'd1;
      end else begin
        cnt <= '0;
      end
      if (state == REQ && state_next == ERR) err_q <= 1'b1;
    end
  end

  assign bus.fetch_err = err_q;
`else
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.inst_req   = (state == REQ);
  assign bus.inst_valid = (state == VALID);
  assign bus.inst_addr  = {pc_w, 2'b00};
  assign bus.pc_out     = {pc_out_w, 2'b00};
  assign bus.inst       = ir;
  assign bus.OPcode     = ir[31:26];
  assign bus.Fun        = ir[5:0];
  assign bus.state_dbg  = state;

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; clock port is clk and reset port is rst.
REQ-002 The block SHALL provide these ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- inst_req  out  1  instruction read request to memory
- inst_addr  out  32  word-aligned fetch address (= PC)
- inst_rdata  in  32  instruction word from memory
- MIO_ready  in  1  memory strobe: inst_rdata is valid this cycle
- inst_valid  out  1  inst holds a fetched, unconsumed instruction
- inst  out  32  instruction register (IR)
- OPcode  out  6  IR[31:26], to controller
- Fun  out  6  IR[5:0], to controller
- pc_out  out  32  address of the instruction in IR
- inst_ack  in  1  downstream has executed inst; advance
- Jump  in  1  controller jump decision for inst
- Branch  in  1  controller branch decision for inst
- Zero  in  1  ALU zero flag for inst
- fetch_err  out  1  sticky fetch timeout flag

Function
REQ-003 The FSM SHALL have states IDLE, REQ, VALID and ERR.
REQ-004 IDLE SHALL last exactly one cycle after reset, then go to REQ.
REQ-005 In REQ, inst_req SHALL be 1 and inst_addr SHALL equal PC; in all other states inst_req SHALL be 0.
REQ-006 In REQ with MIO_ready=1, IR SHALL load inst_rdata, pc_out SHALL load PC, and the FSM SHALL go to VALID on the same edge.
REQ-007 In VALID, inst_valid SHALL be 1, and inst, OPcode and Fun SHALL hold stable until inst_ack.
REQ-008 In VALID with inst_ack=1, on that edge PC SHALL update and the FSM SHALL go to REQ. The PC update priority is:
- Jump=1: {PC4[31:28], IR[25:0], 2'b00}
- else Branch&Zero: PC4 + (sext(IR[15:0]) << 2)
- else: PC4
- PC4 = PC + 4 in every case.
REQ-009 Jump, Branch and Zero SHALL be ignored in any cycle without an accepted inst_ack.
REQ-010 MIO_ready outside REQ and inst_ack outside VALID SHALL be ignored.
REQ-011 Minimum throughput SHALL be one instruction per 2 cycles: MIO_ready in the first REQ cycle gives inst_valid=1 on the next cycle.
REQ-012 All PC arithmetic SHALL be modulo 2^32, so 0xFFFFFFFC + 4 = 0x00000000.
REQ-013 inst_addr[1:0] SHALL always be 2'b00; bits [1:0] of any computed target SHALL be forced to 0.
REQ-014 inst_valid SHALL be 0 in IDLE, REQ and ERR.

Reset
REQ-015 rst=1 at a clock edge SHALL force, from any state including mid-request:
- FSM to IDLE
- PC, IR and pc_out to 0x00000000
- inst_req, inst_valid and fetch_err to 0
- timeout counter to 0
REQ-016 A memory response pending at reset SHALL be discarded; MIO_ready during IDLE has no effect.

Configuration
REQ-017 With macro FETCH_TIMEOUT_EN defined:
- an 8-bit counter SHALL clear on entry to REQ and increment each REQ cycle without MIO_ready
- when the counter reaches 255, the FSM SHALL go to ERR and fetch_err SHALL go to 1
- ERR SHALL hold inst_req=0 until rst
- MIO_ready in the same cycle as count 255 SHALL win: normal capture, no error.
REQ-018 Without FETCH_TIMEOUT_EN:
- no counter SHALL exist
- fetch_err SHALL be tied to 0
- ERR SHALL be unreachable
- REQ SHALL wait indefinitely.

Verification
REQ-019 Reset, then MIO_ready=1 with inst_rdata=0x8C010004 in the first REQ cycle -> inst_addr=0x0; next cycle inst_valid=1, OPcode=0x23, pc_out=0x0.
REQ-020 Sequential: ack with Jump=0 and Branch=0 at PC=0x10 -> next inst_addr=0x14.
REQ-021 Branch taken: IR=0x1022FFFE at PC=0x20, ack with Branch=1 and Zero=1 -> next inst_addr=0x1C. Same IR with Zero=0 -> 0x24.
REQ-022 Jump plus branch: IR=0x08000040 at PC=0x30000000, ack with Jump=1, Branch=1 and Zero=1 -> next inst_addr=0x30000100.
REQ-023 Stall and reset: hold MIO_ready=0 for 10 REQ cycles, then assert rst -> next cycle inst_req=0 and PC=0. Separately, PC=0xFFFFFFFC with sequential ack -> inst_addr=0x0.
REQ-024 Timeout (FETCH_TIMEOUT_EN): no MIO_ready for 255 REQ cycles -> fetch_err=1 and inst_req=0, both held until rst. MIO_ready exactly at count 255 -> inst_valid=1 and fetch_err=0.
